// File: rtl/div_norm_round_if.sv
// div_norm_round_if: handshake and payload bundle between divider, normalizer and posit encoder
interface div_norm_round_if #(
    parameter int MANT_W = 14,
    parameter int TE_W   = 7
);
    localparam int MW     = 3 * MANT_W - 1;
    localparam int FRAC_W = MANT_W - 1;

    logic              in_valid;
    logic              in_ready;
    logic [TE_W-1:0]   te_in;
    logic [MW-1:0]     mant_in;
    logic              out_valid;
    logic              out_ready;
    logic [TE_W-1:0]   te_out;
    logic [FRAC_W-1:0] frac_out;
    logic              round_bit;
    logic              sticky_bit;
    logic              is_zero;
    logic              sat_hi;
    logic              sat_lo;

    modport slave (
        input  in_valid, te_in, mant_in, out_ready,
        output in_ready, out_valid, te_out, frac_out, round_bit, sticky_bit, is_zero, sat_hi, sat_lo
    );

    modport master (
        output in_valid, te_in, mant_in, out_ready,
        input  in_ready, out_valid, te_out, frac_out, round_bit, sticky_bit, is_zero, sat_hi, sat_lo
    );
endinterface

// File: rtl/div_norm_round.sv
// div_norm_round: two-stage normalize / extract-and-saturate pipeline for divider quotients
module div_norm_round #(
    parameter int MANT_W = 14,
    parameter int TE_W   = 7,
    parameter int TE_MAX = 28
) (
    input logic clk,
    input logic rst,
    div_norm_round_if.slave bus
);
    localparam int MW     = 3 * MANT_W - 1;
    localparam int FRAC_W = MANT_W - 1;
    localparam logic signed [TE_W:0] LIM_HI = (TE_W+1)'(TE_MAX);
    localparam logic signed [TE_W:0] LIM_LO = (TE_W+1)'(-TE_MAX);
    localparam logic [TE_W-1:0] TE_HI = TE_W'(TE_MAX);
    localparam logic [TE_W-1:0] TE_LO = TE_W'(-TE_MAX);

    logic                   s1_valid, s2_valid, s1_adv, s2_adv;
    logic                   s1_zero, in_zero, hi, lo;
    logic [MW-1:0]          s1_norm, n_norm;
    logic signed [TE_W:0]   s1_te, te_ext, n_te;
    logic [TE_W-1:0]        r_te;
    logic [FRAC_W-1:0]      r_frac;
    logic                   r_round, r_sticky, r_zero, r_hi, r_lo;

    // handshake chain, normalization of the incoming quotient and clamp detection
    always_comb begin
        s2_adv  = !s2_valid || bus.out_ready;
        s1_adv  = !s1_valid || s2_adv;
        in_zero = bus.mant_in == '0;
        te_ext  = {bus.te_in[TE_W-1], bus.te_in};
        n_norm  = bus.mant_in[MW-1] ? bus.mant_in : bus.mant_in << 1;
        n_te    = in_zero ? '0 : bus.mant_in[MW-1] ? te_ext : te_ext - (TE_W+1)'(1);
        hi      = s1_te > LIM_HI;
        lo      = s1_te < LIM_LO;
    end

    // S1: capture the normalized quotient and adjusted exponent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_norm  <= '0;
            s1_te    <= '0;
            s1_zero  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_norm <= n_norm;
                s1_te   <= n_te;
                s1_zero <= in_zero;
            end
        end
    end

    // S2: split fraction/round/sticky and clamp the exponent; saturated results drop the fraction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            r_te     <= '0;
            r_frac   <= '0;
            r_round  <= 1'b0;
            r_sticky <= 1'b0;
            r_zero   <= 1'b0;
            r_hi     <= 1'b0;
            r_lo     <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                r_te     <= hi ? TE_HI : lo ? TE_LO : s1_te[TE_W-1:0];
                r_frac   <= (hi || lo) ? '0 : s1_norm[MW-2 -: FRAC_W];
                r_round  <= !(hi || lo) && s1_norm[MW-2-FRAC_W];
                r_sticky <= !(hi || lo) && (|s1_norm[MW-3-FRAC_W:0]);
                r_zero   <= s1_zero;
                r_hi     <= hi;
                r_lo     <= lo;
            end
        end
    end

    assign bus.in_ready   = s1_adv;
    assign bus.out_valid  = s2_valid;
    assign bus.te_out     = r_te;
    assign bus.frac_out   = r_frac;
    assign bus.round_bit  = r_round;
    assign bus.sticky_bit = r_sticky;
    assign bus.is_zero    = r_zero;
    assign bus.sat_hi     = r_hi;
    assign bus.sat_lo     = r_lo;
endmodule

// File: tb/tb_div_norm_round.sv
// tb_div_norm_round: random and directed checks of div_norm_round against a behavioural model
module tb_div_norm_round;
    localparam int MW = 41;

    typedef struct packed {
        logic [6:0]  te;
        logic [12:0] frac;
        logic        r, s, z, hi, lo;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, failures = 0, n_in = 0, n_out = 0;
    res_t q[$];
    res_t held;
    logic stalled = 1'b0;

    div_norm_round_if #(.MANT_W(14), .TE_W(7)) bus ();
    div_norm_round #(.MANT_W(14), .TE_W(7), .TE_MAX(28)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: value arithmetic on the quotient, not bit slicing of the pipeline
    function automatic res_t model(input logic [6:0] te_in, input logic [MW-1:0] m);
        res_t o;
        longint t, norm, v;
        o = '0;
        v = longint'(m);
        if (v == 0) begin
            o.z = 1'b1;
            return o;
        end
        t = longint'($signed(te_in));
        if (v >= (64'd1 << 40)) norm = v;
        else begin
            norm = (v * 2) % (64'd1 << 41);
            t = t - 1;
        end
        if (t > 28) begin
            o.te = 7'(28); o.hi = 1'b1;
        end else if (t < -28) begin
            o.te = 7'(-28); o.lo = 1'b1;
        end else begin
            o.te   = 7'(t);
            o.frac = 13'((norm / (64'd1 << 27)) % (64'd1 << 13));
            o.r    = ((norm / (64'd1 << 26)) % 2) != 0;
            o.s    = (norm % (64'd1 << 26)) != 0;
        end
        return o;
    endfunction

    function automatic res_t dut_res();
        res_t o;
        o = '{bus.te_out, bus.frac_out, bus.round_bit, bus.sticky_bit, bus.is_zero, bus.sat_hi, bus.sat_lo};
        return o;
    endfunction

    // Compare process: scoreboard on every transfer, hold-stability while stalled, flag invariants
    always @(negedge clk) begin
        if (rst) stalled <= 1'b0;
        else begin
            if (stalled && bus.out_valid) chk("stall_hold", longint'(dut_res()), longint'(held));
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.te_in, bus.mant_in));
                n_in++;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (q.size() == 0) chk("unexpected_output", 1, 0);
                else chk("scoreboard", longint'(dut_res()), longint'(q.pop_front()));
                chk("flag_excl", longint'(bus.sat_hi && bus.sat_lo), 0);
                chk("zero_nosat", longint'(bus.is_zero && (bus.sat_hi || bus.sat_lo)), 0);
            end
            stalled <= bus.out_valid && !bus.out_ready;
            held    <= dut_res();
        end
    end

    task automatic idle(input int n);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic directed(input string name, input logic [6:0] te, input logic [MW-1:0] m, input res_t e);
        int cyc;
        idle(3);
        bus.in_valid = 1'b1; bus.te_in = te; bus.mant_in = m;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) break;
        end
        chk({name, "_latency"}, cyc, 2);
        chk({name, "_te"}, bus.te_out, e.te);
        chk({name, "_frac"}, bus.frac_out, e.frac);
        chk({name, "_round"}, bus.round_bit, e.r);
        chk({name, "_sticky"}, bus.sticky_bit, e.s);
        chk({name, "_flags"}, {bus.is_zero, bus.sat_hi, bus.sat_lo}, {e.z, e.hi, e.lo});
    endtask

    initial begin
        logic [MW-1:0] bp[3];
        int idx, acc;
        logic rdy;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.te_in = 7'd9; bus.mant_in = 41'd12345;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_payload", longint'(dut_res()), 0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        directed("norm", 7'd3, 41'd1 << 40, '{7'd3, 13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        directed("unnorm", 7'd0, (41'd1 << 39) | (41'd1 << 26), '{7'h7F, 13'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        directed("rs", 7'd5, (41'd1 << 40) | (41'd1 << 26) | 41'd1, '{7'd5, 13'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        directed("sat_hi", 7'd29, (41'd1 << 40) | 41'd77, '{7'd28, 13'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        directed("sat_lo", 7'h64, (41'd1 << 39) | 41'd5, '{7'h64, 13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        directed("zero", 7'd10, 41'd0, '{7'd0, 13'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        // backpressure: three distinct offers while the output is blocked
        idle(3);
        bp[0] = (41'd1 << 40) | 41'd111; bp[1] = (41'd1 << 40) | (41'd5 << 27); bp[2] = 41'd1 << 38;
        bus.out_ready = 1'b0;
        idx = 0; acc = 0;
        bus.in_valid = 1'b1; bus.te_in = 7'd1; bus.mant_in = bp[0];
        repeat (4) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                acc++;
                idx++;
                bus.mant_in = bp[idx > 2 ? 2 : idx];
                bus.te_in   = 7'(idx + 1);
            end
        end
        chk("bp_accepted", acc, 2);
        chk("bp_third_blocked", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        idle(6);
        chk("bp_all_out", n_out, n_in);
        // reset with both stages full
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.te_in = 7'd2; bus.mant_in = 41'd1 << 40;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_full", {bus.out_valid, bus.in_ready}, 2'b10);
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_payload", longint'(dut_res()), 0);
        q.delete();
        n_in = n_out;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        directed("post_rst", 7'd4, (41'd1 << 39) | (41'd1 << 27), '{7'd3, 13'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        // randomized traffic
        repeat (600) begin
            @(posedge clk); #1;
            bus.in_valid  = $urandom_range(0, 3) != 0;
            bus.out_ready = $urandom_range(0, 3) != 0;
            bus.te_in     = 7'($urandom);
            case ($urandom_range(0, 9))
                0:       bus.mant_in = '0;
                1, 2, 3: bus.mant_in = {1'b1, 40'({$urandom, $urandom})};
                default: bus.mant_in = {1'b0, 40'({$urandom, $urandom})};
            endcase
            if ($urandom_range(0, 3) == 0) bus.te_in = 7'($urandom_range(0, 8) + 25) * (($urandom_range(0, 1) != 0) ? 7'd1 : 7'h7F);
        end
        idle(10);
        chk("drain_empty", q.size(), 0);
        chk("in_out_count", n_out, n_in);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_norm_round.md
DIV_NORM_ROUND -- requirements
Module: div_norm_round

Interface
REQ-001 Parameter MANT_W, default 14: mantissa width of the divider operands, hidden bit included.
REQ-002 Parameter TE_W, default 7: signed total-exponent width, two's complement.
REQ-003 Parameter TE_MAX, default 28: largest representable total exponent; the smallest is -TE_MAX.
REQ-004 Derived widths: MW = 3*MANT_W-1 (divider result width); FRAC_W = MANT_W-1.
REQ-005 clk  in  1  single clock for the block; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 in_valid  in  1  upstream divider result valid.
REQ-008 in_ready  out  1  block accepts a result this cycle.
REQ-009 te_in  in  TE_W  signed total exponent from the divider.
REQ-010 mant_in  in  MW  unsigned quotient; bit MW-1 is the integer bit, bits MW-2..0 are fraction.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  downstream posit encoder accepts the result.
REQ-013 te_out  out  TE_W  normalized, saturated total exponent.
REQ-014 frac_out  out  FRAC_W  truncated fraction, hidden bit removed.
REQ-015 round_bit  out  1  first fraction bit below frac_out.
REQ-016 sticky_bit  out  1  OR of all fraction bits below round_bit.
REQ-017 is_zero, sat_hi, sat_lo  out  1 each  zero-quotient flag and exponent-clamp flags.

Function
REQ-018 The block SHALL be a two-stage pipeline, S1 (normalize) then S2 (extract/saturate), each stage holding a valid bit and a payload register.
REQ-019 A transfer SHALL occur on a cycle where both valid and ready are high, for the input and the output alike.
REQ-020 S2 advance: s2_adv = !s2_valid || out_ready.
REQ-021 S1 advance: s1_adv = !s1_valid || s2_adv.
REQ-022 in_ready SHALL equal s1_adv; a combinational path from out_ready to in_ready is permitted.
REQ-023 Latency SHALL be 2 cycles from input transfer to out_valid, with out_ready held high.
REQ-024 Throughput SHALL be 1 result per cycle.
REQ-025 A stalled stage SHALL hold its payload and valid unchanged.
REQ-026 Results SHALL leave in order, with no loss and no duplication.
REQ-027 S1, mant_in[MW-1]=1: norm = mant_in; te = te_in.
REQ-028 S1, mant_in[MW-1]=0 and mant_in != 0: norm = mant_in << 1; te = te_in - 1, computed with TE_W+1-bit internal width.
REQ-029 S1, mant_in = 0: zero flag set; norm = 0; te = 0.
REQ-030 S2: frac_out = norm[MW-2 : MW-1-FRAC_W].
REQ-031 S2: round_bit = norm[MW-2-FRAC_W].
REQ-032 S2: sticky_bit = |norm[MW-3-FRAC_W : 0].
REQ-033 S2, te > TE_MAX: te_out = TE_MAX; sat_hi = 1; frac_out, round_bit, sticky_bit all forced to 0.
REQ-034 S2, te < -TE_MAX: te_out = -TE_MAX; sat_lo = 1; frac_out, round_bit, sticky_bit all forced to 0.
REQ-035 sat_hi and sat_lo SHALL never both be 1.
REQ-036 When is_zero = 1, sat_hi and sat_lo SHALL be 0.
REQ-037 Payload outputs are don't-care while out_valid = 0, but SHALL remain stable while out_valid = 1 and out_ready = 0.

Reset
REQ-038 rst high SHALL immediately clear s1_valid and s2_valid, forcing out_valid = 0.
REQ-039 rst high SHALL force te_out, frac_out, round_bit, sticky_bit, is_zero, sat_hi and sat_lo to 0.
REQ-040 in_ready SHALL read 1 during reset and after it.
REQ-041 A transaction in flight when rst asserts SHALL be discarded and never emitted.
REQ-042 Inputs SHALL be ignored while rst is high.
REQ-043 Normal operation SHALL resume on the first clock edge after rst deasserts.

Verification
REQ-044 Normalized input, defaults: mant_in=1<<40, te_in=3 -> 2 cycles later te_out=3, frac_out=0, round_bit=0, sticky_bit=0, all flags 0.
REQ-045 Unnormalized input: mant_in=(1<<39)|(1<<26), te_in=0 -> te_out=-1 (7'h7F), frac_out=13'h0001, round_bit=0, sticky_bit=0.
REQ-046 Round/sticky extraction: mant_in=(1<<40)|(1<<26)|1, te_in=5 -> frac_out=0, round_bit=1, sticky_bit=1, te_out=5.
REQ-047 Saturation and zero: te_in=29 with MSB set -> te_out=28, sat_hi=1; te_in=-28 with MSB clear -> te_out=-28, sat_lo=1; mant_in=0 -> is_zero=1, te_out=0.
REQ-048 Backpressure: out_ready=0 for 4 cycles with in_valid=1 and 3 distinct inputs offered -> exactly 2 accepted, in_ready=0 on the third; after out_ready=1, all 3 emerge in order, each exactly once.
REQ-049 Reset mid-operation: assert rst with both stages valid -> out_valid=0 and in_ready=1 at once; the first output after release corresponds to the first post-reset input.
